// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus for the fetch unit.
// Ports: req/addr (fetch side drives), ready/rdata (memory side drives).
interface pc_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: issues imem requests, buffers one word
// under stall, takes branch/jump/JR redirects from decode.
// Ports: clk/rst, stall, redirect_*/br_*/j_target/jr_addr from decode,
// imem (master bus), if_* to decode, err_misaligned pulse.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter int          ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_sel,
    input  logic [ADDR_W-1:0] br_pc4,
    input  logic [15:0]       br_imm,
    input  logic [25:0]       j_target,
    input  logic [ADDR_W-1:0] jr_addr,
    pc_fetch_unit_if.master   imem,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic              err_misaligned
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              kill;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic [ADDR_W-1:0] target;
    logic              jr_mis;
    logic              done;

    always_comb begin
        target = '0;
        unique case (1'b1)
            redirect_sel == 2'b01:
                target = {br_pc4[31:28], j_target, 2'b00};
            redirect_sel == 2'b10:
                target = {jr_addr[31:2], 2'b00};
            default:
                target = br_pc4
                       + {{14{br_imm[15]}}, br_imm, 2'b00};
        endcase
    end

    assign jr_mis = redirect_valid
                  && (redirect_sel == 2'b10)
                  && (jr_addr[1:0] != 2'b00);

    assign done = imem.req && imem.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH;
            pc             <= RESET_VECTOR;
            kill           <= 1'b0;
            skid_instr     <= '0;
            skid_pc        <= '0;
            imem.req       <= 1'b1;
            imem.addr      <= RESET_VECTOR;
            if_valid       <= 1'b0;
            if_instr       <= '0;
            if_pc          <= '0;
            if_pc4         <= '0;
            err_misaligned <= 1'b0;
        end else begin
            err_misaligned <= jr_mis;
            unique case (state)
                FETCH: begin
                    if (done) begin
                        if (kill || redirect_valid) begin
                            // Word belongs to a flushed path.
                            kill     <= 1'b0;
                            if_valid <= 1'b0;
                            if (redirect_valid) begin
                                pc        <= target;
                                imem.addr <= target;
                            end else begin
                                imem.addr <= pc;
                            end
                        end else if (!if_valid || !stall) begin
                            if_valid  <= 1'b1;
                            if_instr  <= imem.rdata;
                            if_pc     <= pc;
                            if_pc4    <= pc + 32'd4;
                            pc        <= pc + 32'd4;
                            imem.addr <= pc + 32'd4;
                        end else begin
                            skid_instr <= imem.rdata;
                            skid_pc    <= pc;
                            pc         <= pc + 32'd4;
                            imem.req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Request in flight: keep bus stable,
                        // drop its word when it lands.
                        kill     <= 1'b1;
                        pc       <= target;
                        if_valid <= 1'b0;
                    end else if (if_valid && !stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        if_valid  <= 1'b0;
                        pc        <= target;
                        imem.addr <= target;
                        imem.req  <= 1'b1;
                        state     <= FETCH;
                    end else if (!stall) begin
                        if_valid  <= 1'b1;
                        if_instr  <= skid_instr;
                        if_pc     <= skid_pc;
                        if_pc4    <= skid_pc + 32'd4;
                        imem.addr <= pc;
                        imem.req  <= 1'b1;
                        state     <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Memory returns addr ^ K so each word identifies its address.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] K  = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic [25:0] j_target;
    logic [31:0] jr_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        err_misaligned;

    int checks;
    int errors;

    pc_fetch_unit_if bus ();

    assign bus.rdata = bus.addr ^ K;

    pc_fetch_unit #(
        .RESET_VECTOR(RV),
        .ADDR_W      (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_sel  (redirect_sel),
        .br_pc4        (br_pc4),
        .br_imm        (br_imm),
        .j_target      (j_target),
        .jr_addr       (jr_addr),
        .imem          (bus.master),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4),
        .err_misaligned(err_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag,
                           input logic v,
                           input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_pc"}, if_pc, pc);
            chk({tag, "_pc4"}, if_pc4, pc + 32'd4);
            chk({tag, "_instr"}, if_instr, pc ^ K);
        end
    endtask

    task automatic chk_bus(input string tag,
                           input logic r,
                           input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, bus.req}, {31'd0, r});
        if (r) chk({tag, "_addr"}, bus.addr, a);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_sel   = 2'b00;
        br_pc4         = '0;
        br_imm         = '0;
        j_target       = '0;
        jr_addr        = '0;
        bus.ready      = 1'b1;

        // 1: reset values, then one word per cycle
        do_reset();
        chk_bus("rst", 1'b1, RV);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);
        chk("rst_err", {31'd0, err_misaligned}, 32'd0);
        step();
        chk_bus("t1a", 1'b1, RV + 32'd4);
        chk_out("t1a", 1'b1, RV);
        step();
        chk_bus("t1b", 1'b1, RV + 32'd8);
        chk_out("t1b", 1'b1, RV + 32'd4);
        step();
        chk_bus("t1c", 1'b1, RV + 32'd12);
        chk_out("t1c", 1'b1, RV + 32'd8);

        // 2: memory wait states
        do_reset();
        step();
        bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bus("t2wait", 1'b1, RV + 32'd4);
            chk_out("t2wait", 1'b0, 32'd0);
        end
        bus.ready = 1'b1;
        step();
        chk_bus("t2done", 1'b1, RV + 32'd8);
        chk_out("t2done", 1'b1, RV + 32'd4);
        bus.ready = 1'b0;
        step();
        chk_out("t2once", 1'b0, 32'd0);
        chk_bus("t2once", 1'b1, RV + 32'd8);

        // 3: stall into skid buffer
        bus.ready = 1'b1;
        do_reset();
        step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_bus("t3hold", 1'b0, 32'd0);
            chk_out("t3hold", 1'b1, RV);
        end
        stall = 1'b0;
        step();
        chk_bus("t3rel", 1'b1, RV + 32'd8);
        chk_out("t3rel", 1'b1, RV + 32'd4);
        step();
        chk_bus("t3next", 1'b1, RV + 32'd12);
        chk_out("t3next", 1'b1, RV + 32'd8);

        // 4: branch, jump, JR
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_sel   = 2'b00;
        br_pc4         = 32'h0040_0010;
        br_imm         = 16'hFFFC;
        step();
        redirect_valid = 1'b0;
        chk_bus("t4br", 1'b1, 32'h0040_0000);
        chk_out("t4br", 1'b0, 32'd0);
        step();
        chk_out("t4br_w", 1'b1, 32'h0040_0000);

        redirect_valid = 1'b1;
        redirect_sel   = 2'b01;
        j_target       = 26'h010_0020;
        step();
        redirect_valid = 1'b0;
        chk_bus("t4j", 1'b1, 32'h0040_0080);
        chk_out("t4j", 1'b0, 32'd0);
        step();
        chk_out("t4j_w", 1'b1, 32'h0040_0080);

        redirect_valid = 1'b1;
        redirect_sel   = 2'b10;
        jr_addr        = 32'h0040_0023;
        step();
        redirect_valid = 1'b0;
        chk_bus("t4jr", 1'b1, 32'h0040_0020);
        chk("t4jr_err", {31'd0, err_misaligned}, 32'd1);
        step();
        chk("t4jr_err1", {31'd0, err_misaligned}, 32'd0);
        chk_out("t4jr_w", 1'b1, 32'h0040_0020);

        // 5: redirect during a wait, and redirect with stall
        do_reset();
        step();
        step();
        bus.ready = 1'b0;
        step();
        chk_bus("t5wait", 1'b1, RV + 32'd8);
        redirect_valid = 1'b1;
        redirect_sel   = 2'b01;
        br_pc4         = 32'h0040_0010;
        j_target       = 26'h010_0020;
        step();
        redirect_valid = 1'b0;
        chk_bus("t5kill0", 1'b1, RV + 32'd8);
        chk_out("t5kill0", 1'b0, 32'd0);
        step();
        chk_bus("t5kill1", 1'b1, RV + 32'd8);
        bus.ready = 1'b1;
        step();
        chk_bus("t5drop", 1'b1, 32'h0040_0080);
        chk_out("t5drop", 1'b0, 32'd0);
        step();
        chk_bus("t5tgt", 1'b1, 32'h0040_0084);
        chk_out("t5tgt", 1'b1, 32'h0040_0080);

        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_sel   = 2'b00;
        br_imm         = 16'h0004;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk_out("t5flush", 1'b0, 32'd0);
        chk_bus("t5flush", 1'b1, 32'h0040_0020);
        step();
        chk_out("t5flush_w", 1'b1, 32'h0040_0020);

        // 6: reset mid-HOLD, reset mid-wait, PC wrap
        do_reset();
        step();
        stall = 1'b1;
        step();
        chk_bus("t6hold", 1'b0, 32'd0);
        rst = 1'b1;
        step();
        chk_bus("t6rh", 1'b1, RV);
        chk("t6rh_valid", {31'd0, if_valid}, 32'd0);
        chk("t6rh_pc", if_pc, 32'd0);
        chk("t6rh_pc4", if_pc4, 32'd0);
        chk("t6rh_instr", if_instr, 32'd0);
        rst   = 1'b0;
        stall = 1'b0;
        step();
        chk_out("t6rh_w", 1'b1, RV);

        bus.ready = 1'b0;
        step();
        chk_bus("t6wait", 1'b1, RV + 32'd4);
        rst = 1'b1;
        step();
        chk_bus("t6rw", 1'b1, RV);
        chk("t6rw_valid", {31'd0, if_valid}, 32'd0);
        rst       = 1'b0;
        bus.ready = 1'b1;
        step();
        chk_out("t6rw_w", 1'b1, RV);

        redirect_valid = 1'b1;
        redirect_sel   = 2'b10;
        jr_addr        = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk_bus("t6jr", 1'b1, 32'hFFFF_FFFC);
        chk("t6jr_err", {31'd0, err_misaligned}, 32'd0);
        step();
        chk_bus("t6wrap", 1'b1, 32'h0000_0000);
        chk_out("t6wrap", 1'b1, 32'hFFFF_FFFC);
        chk("t6wrap_err", {31'd0, err_misaligned}, 32'd0);
        step();
        chk_out("t6zero", 1'b1, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the MIPS datapath.
- Holds PC and requests instructions from instruction memory over a req/ready handshake.
- Presents fetched words to decode with PC and PC+4 attached, and accepts branch/jump/JR redirects back from decode.
- Computes next PC (sequential +4, branch, jump, register jump) and owns stall buffering. No delay slot: a redirect flushes every younger fetch.

Parameters:
RESET_VECTOR, 32'h0040_0000, first fetch address after reset
ADDR_W, 32, PC/address width (fixed at 32; kept for documentation)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  decode cannot accept; hold if_* outputs
redirect_valid  input  1  one-cycle redirect request from decode
redirect_sel  input  2  00 branch, 01 jump (J/JAL), 10 jump register, 11 reserved (treated as branch)
br_pc4  input  32  PC+4 of the redirecting instruction
br_imm  input  16  branch immediate (word offset)
j_target  input  26  jump index field
jr_addr  input  32  register value for JR/JALR
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_ready  input  1  memory accepts/returns this cycle
imem_rdata  input  32  instruction, valid when imem_req && imem_ready
if_valid  output  1  if_* holds a live instruction
if_instr  output  32  fetched instruction
if_pc  output  32  address of if_instr
if_pc4  output  32  if_pc + 4
err_misaligned  output  1  one-cycle pulse: JR target low bits nonzero

Behaviour:
- Reset (synchronous, priority over everything):
  - pc = RESET_VECTOR; state = FETCH; if_valid = 0; if_instr/if_pc/if_pc4 = 0.
  - Skid buffer empty; kill flag = 0; err_misaligned = 0.
  - imem_req = 1 from the first cycle after reset deasserts, with imem_addr = RESET_VECTOR.
- Handshake:
  - imem_req/imem_addr are registered.
  - Once imem_req is high, it and imem_addr stay stable until a cycle with imem_ready = 1 (the completion). Neither stall nor redirect alters them mid-request.
  - Data is taken from imem_rdata in the completion cycle.
- FSM states:
  - FETCH: imem_req = 1. On completion:
    - Kill flag set, or redirect_valid this cycle → discard the word, clear kill, pc = redirect target (or the already-loaded pc if kill), stay FETCH.
    - Else output free (!if_valid || !stall) → load if_instr = rdata, if_pc = pc, if_pc4 = pc+4, if_valid = 1, pc = pc+4.
    - Else (output held) → store word/pc in skid buffer, pc = pc+4, go HOLD.
  - HOLD: imem_req = 0. When stall = 0, move skid to if_*, go FETCH. Redirect in HOLD → drop skid, clear if_valid, pc = target, go FETCH.
- Output consumption: if_valid && !stall at an edge with no new word → if_valid = 0.
- Redirect, any state:
  - Clears if_valid next edge; takes priority over stall and over same-cycle completion.
  - If a request is outstanding and not completing this cycle → set kill and load pc = target. The next request issues at the target only after the killed completion.
- Target arithmetic (32-bit, modulo 2^32, overflow ignored):
  - branch = br_pc4 + (sign_extend(br_imm) << 2).
  - jump = {br_pc4[31:28], j_target, 2'b00}.
  - JR = {jr_addr[31:2], 2'b00}; err_misaligned pulses for one cycle if jr_addr[1:0] != 0.
- Sequential wrap: 0xFFFFFFFC + 4 = 0x00000000; no error.
- Throughput: with imem_ready tied high and no stall, one instruction per cycle. Addresses are consecutive, and if_valid rises 1 cycle after the first request.
- Reset mid-request abandons the request; memory must tolerate the request vanishing.

Test Plan:
1. Reset, RESET_VECTOR = 0x00400000, imem_ready = 1 → imem_addr 0x00400000, 0x00400004, 0x00400008 on successive cycles; if_pc4 = if_pc + 4; if_valid continuous.
2. imem_ready low 3 cycles at addr 0x00400004 → imem_req/imem_addr stable 3 cycles; if_valid drops after consumption; word delivered once when ready returns.
3. stall high 4 cycles with ready = 1 → one word captured in skid, imem_req = 0. On release, words 0x00400004 and 0x00400008 delivered in order, none lost or duplicated.
4. Redirects:
   - branch br_pc4 = 0x00400010, br_imm = 0xFFFC → next fetch 0x00400000.
   - jump br_pc4 = 0x00400010, j_target = 0x0100020 → 0x00400080.
   - JR jr_addr = 0x00400023 → fetch 0x00400020, err_misaligned one pulse.
5. Redirect while request at 0x00400008 waits (ready low 2 more cycles) → that returned word discarded (if_valid stays 0); next imem_addr = target. Also: redirect and stall the same cycle → flush wins.
6. Reset asserted mid-HOLD and mid-wait → next cycle all outputs at reset values, fetch restarts at RESET_VECTOR. Separately, pc 0xFFFFFFFC → next imem_addr 0x00000000.
